dmux_nway_reg: RTL and testbench



---
 rtl/dmux_nway_reg_pkg.sv | 10 +
 rtl/dmux_nway_reg_slot.sv | 44 ++++
 rtl/dmux_nway_reg.sv | 76 +++++++
 tb/tb_dmux_nway_reg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_nway_reg_pkg.sv
// Shared definitions for the registered N-way demultiplexer.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Holds the Hack machine word width used as the default data width.
package dmux_nway_reg_pkg;

    // Hack word width in bits.
    localparam int WORD_W = 16;

endpackage

// File: rtl/dmux_nway_reg_slot.sv
// One-entry output register with valid/ready handshake for one demux channel.
// Latency: a write at edge k is visible on out_data/out_valid right after edge k.
// Backpressure: free is low while a word sits unconsumed (out_valid && !out_ready).
//
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   wr_en       - load wr_data into the slot on this edge
//   wr_data     - word to load
//   out_data    - registered word, held until overwritten
//   out_valid   - slot holds a word the consumer has not yet taken
//   out_ready   - consumer takes the word on an edge where out_valid=1
//   free        - slot can accept a write this cycle (empty or draining now)
import dmux_nway_reg_pkg::*;

module dmux_slot #(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             free
);

    // A slot being drained this cycle may be refilled on the same edge.
    assign free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (wr_en) begin
            // Refill wins over drain: valid stays high, no bubble.
            out_valid <= 1'b1;
            out_data  <= wr_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux_nway_reg.sv
// Registered N-way demultiplexer: routes one word to a selected channel or broadcasts to all.
// Latency: one cycle; a word accepted at edge k appears on its channel(s) right after edge k.
// Backpressure: in_ready drops unless every targeted slot is free; broadcast is all-or-nothing.
//
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   in_data/in_sel       - word and destination channel (in_sel ignored when in_bcast=1)
//   in_bcast             - deliver in_data to all N channels
//   in_valid/in_ready    - source handshake; in_ready is combinational, independent of in_valid
//   out_data             - channel i data at [i*WIDTH +: WIDTH]
//   out_valid/out_ready  - per-channel consumer handshake
//   stall_cnt            - saturating count of cycles with in_valid=1 and in_ready=0
import dmux_nway_reg_pkg::*;

module dmux_nway_reg #(
    parameter int WIDTH = WORD_W,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16,
    localparam int N    = 2**SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [N-1:0] tgt;
    logic [N-1:0] free;
    logic         accept;

    // Target set: one-hot channel select, or every channel on broadcast.
    always_comb begin
        tgt = '0;
        if (in_bcast) begin
            tgt = '1;
        end else begin
            tgt[in_sel] = 1'b1;
        end
    end

    // Ready only if every targeted slot is free, so a broadcast never lands partially.
    assign in_ready = &(free | ~tgt);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < N; i++) begin : g_slot
        dmux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (accept && tgt[i]),
            .wr_data   (in_data),
            .out_data  (out_data[i*WIDTH +: WIDTH]),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .free      (free[i])
        );
    end

    // Saturates at all-ones rather than wrapping; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmux_nway_reg.sv
module tb_dmux_nway_reg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;
    localparam int N     = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_bcast;
    logic             in_valid;
    logic             in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-channel expected words, in delivery order.
    logic [WIDTH-1:0] expq [N][$];

    always #5 clk = ~clk;

    dmux_nway_reg #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [WIDTH-1:0] chan(input int i);
        return out_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [WIDTH-1:0] d);
        expq[ch].push_back(d);
    endtask

    // Monitor: at the falling edge, a valid && ready channel will hand its word
    // over on the next rising edge, so pop and compare it then. Also checks
    // that a stalled word does not change.
    logic [N-1:0]       prev_stall = '0;
    logic [N*WIDTH-1:0] prev_data  = '0;
    logic               prev_reset = 1'b1;

    always @(negedge clk) begin
        if (!prev_reset) begin
            for (int i = 0; i < N; i++) begin
                if (prev_stall[i]) begin
                    check($sformatf("stable_valid_ch%0d", i), 32'(out_valid[i]), 32'd1);
                    check($sformatf("stable_data_ch%0d", i), 32'(chan(i)),
                          32'(prev_data[i*WIDTH +: WIDTH]));
                end
            end
        end
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (expq[i].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_word_ch%0d: got %h, expected none", i, chan(i));
                    end else begin
                        check($sformatf("scoreboard_ch%0d", i), 32'(chan(i)),
                              32'(expq[i].pop_front()));
                    end
                end
            end
        end
        prev_stall = out_valid & ~out_ready;
        prev_data  = out_data;
        prev_reset = reset;
    end

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_bcast  = 1'b0;
        in_valid  = 1'b0;
        out_ready = '0;

        // Reset state
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'h00);
        check("rst_out_data", 32'(out_data == '0), 32'd1);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Unicast with all consumers ready
        out_ready = 8'hFF;
        in_sel    = 3'd5;
        in_data   = 16'hBEEF;
        in_valid  = 1'b1;
        push(5, 16'hBEEF);
        #1;
        check("uni_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("uni_out_valid", 32'(out_valid), 32'h20);
        check("uni_ch5_data", 32'(chan(5)), 32'hBEEF);
        step();
        check("uni_drained", 32'(out_valid), 32'h00);

        // Backpressure on channel 2
        out_ready = 8'hFB;
        in_sel    = 3'd2;
        in_data   = 16'h0001;
        in_valid  = 1'b1;
        push(2, 16'h0001);
        #1;
        check("bp_first_ready", 32'(in_ready), 32'd1);
        step();
        in_data = 16'h0002;
        push(2, 16'h0002);
        #1;
        check("bp_second_blocked", 32'(in_ready), 32'd0);
        step();
        check("bp_hold_data", 32'(chan(2)), 32'h0001);
        check("bp_stall_1", 32'(stall_cnt), 32'd1);
        step();
        check("bp_stall_2", 32'(stall_cnt), 32'd2);
        out_ready = 8'hFF;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_no_bubble_valid", 32'(out_valid), 32'h04);
        check("bp_refill_data", 32'(chan(2)), 32'h0002);
        check("bp_stall_frozen", 32'(stall_cnt), 32'd2);
        step();

        // Broadcast all-or-nothing
        out_ready = 8'hF7;
        in_sel    = 3'd3;
        in_data   = 16'h0033;
        in_valid  = 1'b1;
        push(3, 16'h0033);
        step();
        check("bc_ch3_loaded", 32'(out_valid), 32'h08);
        in_bcast = 1'b1;
        in_data  = 16'h1234;
        for (int i = 0; i < N; i++) push(i, 16'h1234);
        #1;
        check("bc_blocked_ready", 32'(in_ready), 32'd0);
        step();
        check("bc_no_partial_valid", 32'(out_valid), 32'h08);
        check("bc_no_partial_ch0", 32'(chan(0)), 32'h0000);
        check("bc_stall_3", 32'(stall_cnt), 32'd3);
        out_ready = 8'hFF;
        #1;
        check("bc_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        check("bc_all_valid", 32'(out_valid), 32'hFF);
        for (int i = 0; i < N; i++)
            check($sformatf("bc_data_ch%0d", i), 32'(chan(i)), 32'h1234);
        step();
        check("bc_drained", 32'(out_valid), 32'h00);

        // Back-to-back streaming, alternating channels 0 and 1
        out_ready = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            in_sel   = 3'(k % 2);
            in_data  = 16'h0A00 + 16'(k);
            in_valid = 1'b1;
            push(k % 2, 16'h0A00 + 16'(k));
            #1;
            check($sformatf("stream_ready_%0d", k), 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(out_valid), 32'h00);
        step();
        for (int i = 0; i < N; i++)
            check($sformatf("queue_empty_ch%0d", i), 32'(expq[i].size()), 32'd0);

        // Saturation then mid-operation reset
        out_ready = 8'hFE;
        in_sel    = 3'd0;
        in_data   = 16'h5555;
        in_valid  = 1'b1;
        push(0, 16'h5555);
        step();
        in_data = 16'h6666;
        repeat (20) step();
        check("sat_at_max", 32'(stall_cnt), 32'd15);
        step();
        check("sat_no_wrap", 32'(stall_cnt), 32'd15);
        check("sat_ch0_held", 32'(chan(0)), 32'h5555);
        check("sat_valid", 32'(out_valid), 32'h01);
        reset = 1'b1;
        step();
        check("mid_rst_stall", 32'(stall_cnt), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'h00);
        check("mid_rst_ch0", 32'(chan(0)), 32'h0000);
        for (int i = 0; i < N; i++) expq[i].delete();
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check("post_rst_valid", 32'(out_valid), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
